// File: rtl/id_exe_reg.sv
// ----------------------------------------------------------------------------
// id_exe_reg
// ID/EXE pipeline register of the ARM core. It captures the decoded control
// bits, register-file operands, immediate/shift fields, register numbers and
// the carry flag, and presents them to the execute stage one cycle later.
//
// Per rising edge, highest priority first:
//   freeze=1 -> HOLD   : everything keeps its value, stall_cnt counts
//   flush=1  -> BUBBLE : control bits and valid become 0, data fields load,
//                        flush_cnt counts
//   else     -> LOAD   : every output captures its input
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   freeze, flush          hazard stall / branch-taken bubble request
//   *_in                   decoded instruction from the ID stage
//   *_out                  registered copies for the EXE stage
//   stall_cnt, flush_cnt   saturating debug event counters
// ----------------------------------------------------------------------------
module id_exe_reg #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [DW-1:0]    pc_in,
    input  logic [3:0]       exe_cmd_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             wb_en_in,
    input  logic             s_in,
    input  logic             b_in,
    input  logic [DW-1:0]    val_rn_in,
    input  logic [DW-1:0]    val_rm_in,
    input  logic             imm_in,
    input  logic [11:0]      shift_operand_in,
    input  logic [23:0]      signed_imm24_in,
    input  logic [3:0]       dest_in,
    input  logic [3:0]       src1_in,
    input  logic [3:0]       src2_in,
    input  logic             c_in,
    output logic             valid_out,
    output logic [DW-1:0]    pc_out,
    output logic [3:0]       exe_cmd_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic             wb_en_out,
    output logic             s_out,
    output logic             b_out,
    output logic [DW-1:0]    val_rn_out,
    output logic [DW-1:0]    val_rm_out,
    output logic             imm_out,
    output logic [11:0]      shift_operand_out,
    output logic [23:0]      signed_imm24_out,
    output logic [3:0]       dest_out,
    output logic [3:0]       src1_out,
    output logic [3:0]       src2_out,
    output logic             c_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Control group (zeroed on a bubble)
    logic          valid_q,     valid_d;
    logic [3:0]    exe_cmd_q,   exe_cmd_d;
    logic          mem_read_q,  mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          wb_en_q,     wb_en_d;
    logic          s_q,         s_d;
    logic          b_q,         b_d;

    // Data group (loads on LOAD and BUBBLE, holds on HOLD)
    logic [DW-1:0] pc_q,            pc_d;
    logic [DW-1:0] val_rn_q,        val_rn_d;
    logic [DW-1:0] val_rm_q,        val_rm_d;
    logic          imm_q,           imm_d;
    logic [11:0]   shift_operand_q, shift_operand_d;
    logic [23:0]   signed_imm24_q,  signed_imm24_d;
    logic [3:0]    dest_q,          dest_d;
    logic [3:0]    src1_q,          src1_d;
    logic [3:0]    src2_q,          src2_d;
    logic          c_q,             c_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        // Default: HOLD
        valid_d         = valid_q;
        exe_cmd_d       = exe_cmd_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        wb_en_d         = wb_en_q;
        s_d             = s_q;
        b_d             = b_q;
        pc_d            = pc_q;
        val_rn_d        = val_rn_q;
        val_rm_d        = val_rm_q;
        imm_d           = imm_q;
        shift_operand_d = shift_operand_q;
        signed_imm24_d  = signed_imm24_q;
        dest_d          = dest_q;
        src1_d          = src1_q;
        src2_d          = src2_q;
        c_d             = c_q;
        stall_cnt_d     = stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;

        if (freeze) begin
            // Freeze wins over flush; a pending flush is re-issued later.
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
        end else begin
            // Data fields load in both BUBBLE and LOAD; they are ignored
            // downstream when valid is low.
            pc_d            = pc_in;
            val_rn_d        = val_rn_in;
            val_rm_d        = val_rm_in;
            imm_d           = imm_in;
            shift_operand_d = shift_operand_in;
            signed_imm24_d  = signed_imm24_in;
            dest_d          = dest_in;
            src1_d          = src1_in;
            src2_d          = src2_in;
            c_d             = c_in;

            if (flush) begin
                valid_d     = 1'b0;
                exe_cmd_d   = 4'd0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                wb_en_d     = 1'b0;
                s_d         = 1'b0;
                b_d         = 1'b0;
                if (flush_cnt_q != CNT_MAX) begin
                    flush_cnt_d = flush_cnt_q + CNT_ONE;
                end
            end else begin
                // No masking on valid_in=0: the control unit already drives
                // zero control for invalid instructions.
                valid_d     = valid_in;
                exe_cmd_d   = exe_cmd_in;
                mem_read_d  = mem_read_in;
                mem_write_d = mem_write_in;
                wb_en_d     = wb_en_in;
                s_d         = s_in;
                b_d         = b_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q         <= 1'b0;
            exe_cmd_q       <= 4'd0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            wb_en_q         <= 1'b0;
            s_q             <= 1'b0;
            b_q             <= 1'b0;
            pc_q            <= '0;
            val_rn_q        <= '0;
            val_rm_q        <= '0;
            imm_q           <= 1'b0;
            shift_operand_q <= 12'd0;
            signed_imm24_q  <= 24'd0;
            dest_q          <= 4'd0;
            src1_q          <= 4'd0;
            src2_q          <= 4'd0;
            c_q             <= 1'b0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            valid_q         <= valid_d;
            exe_cmd_q       <= exe_cmd_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            wb_en_q         <= wb_en_d;
            s_q             <= s_d;
            b_q             <= b_d;
            pc_q            <= pc_d;
            val_rn_q        <= val_rn_d;
            val_rm_q        <= val_rm_d;
            imm_q           <= imm_d;
            shift_operand_q <= shift_operand_d;
            signed_imm24_q  <= signed_imm24_d;
            dest_q          <= dest_d;
            src1_q          <= src1_d;
            src2_q          <= src2_d;
            c_q             <= c_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign valid_out         = valid_q;
    assign exe_cmd_out       = exe_cmd_q;
    assign mem_read_out      = mem_read_q;
    assign mem_write_out     = mem_write_q;
    assign wb_en_out         = wb_en_q;
    assign s_out             = s_q;
    assign b_out             = b_q;
    assign pc_out            = pc_q;
    assign val_rn_out        = val_rn_q;
    assign val_rm_out        = val_rm_q;
    assign imm_out           = imm_q;
    assign shift_operand_out = shift_operand_q;
    assign signed_imm24_out  = signed_imm24_q;
    assign dest_out          = dest_q;
    assign src1_out          = src1_q;
    assign src2_out          = src2_q;
    assign c_out             = c_q;
    assign stall_cnt         = stall_cnt_q;
    assign flush_cnt         = flush_cnt_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// ----------------------------------------------------------------------------
// tb_id_exe_reg
// Directed bench for the ID/EXE pipeline register (counters built 4 bits
// wide so saturation is reachable). A reference model tracks what the stage
// must present; a compare process checks it every falling edge, and directed
// literal checks pin the model at the interesting points.
// Inputs change only just after a falling edge; outputs are sampled on the
// falling edge, away from the rising capture edge.
// ----------------------------------------------------------------------------
module tb_id_exe_reg;

    localparam int DW      = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic             freeze, flush, valid_in;
    logic [DW-1:0]    pc_in, val_rn_in, val_rm_in;
    logic [3:0]       exe_cmd_in, dest_in, src1_in, src2_in;
    logic             mem_read_in, mem_write_in, wb_en_in, s_in, b_in, imm_in, c_in;
    logic [11:0]      shift_operand_in;
    logic [23:0]      signed_imm24_in;

    logic             valid_out, mem_read_out, mem_write_out, wb_en_out, s_out, b_out, imm_out, c_out;
    logic [DW-1:0]    pc_out, val_rn_out, val_rm_out;
    logic [3:0]       exe_cmd_out, dest_out, src1_out, src2_out;
    logic [11:0]      shift_operand_out;
    logic [23:0]      signed_imm24_out;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    id_exe_reg #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .exe_cmd_in(exe_cmd_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .wb_en_in(wb_en_in), .s_in(s_in), .b_in(b_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .c_in(c_in),
        .valid_out(valid_out), .pc_out(pc_out), .exe_cmd_out(exe_cmd_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .wb_en_out(wb_en_out), .s_out(s_out), .b_out(b_out),
        .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
        .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
        .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .c_out(c_out),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Instruction packed as two vectors: control (10 bits) and data (146 bits)
    localparam int CW = 10;
    localparam int XW = 3*DW + 1 + 12 + 24 + 4*3 + 1;

    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [XW-1:0] in_data, out_data;

    assign in_ctrl  = {valid_in, exe_cmd_in, mem_read_in, mem_write_in, wb_en_in, s_in, b_in};
    assign out_ctrl = {valid_out, exe_cmd_out, mem_read_out, mem_write_out, wb_en_out, s_out, b_out};
    assign in_data  = {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm24_in,
                       dest_in, src1_in, src2_in, c_in};
    assign out_data = {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm24_out,
                       dest_out, src1_out, src2_out, c_out};

    // ---------------- scoreboard / counters ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // What the EXE stage must see: the last instruction accepted, a bubble
    // if a flush was accepted, unchanged across freezes. Data content after
    // a bubble is unspecified, so it is not checked until the next load.
    logic [CW-1:0] exp_ctrl;
    logic [XW-1:0] exp_data;
    bit            data_known;
    int            exp_stall, exp_flush;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_ctrl   = '0;
            exp_data   = '0;
            data_known = 1'b1;
            exp_stall  = 0;
            exp_flush  = 0;
        end else if (freeze) begin
            exp_stall = (exp_stall < CNT_MAX) ? exp_stall + 1 : CNT_MAX;
        end else if (flush) begin
            exp_ctrl   = '0;
            data_known = 1'b0;
            exp_flush  = (exp_flush < CNT_MAX) ? exp_flush + 1 : CNT_MAX;
        end else begin
            exp_ctrl   = in_ctrl;
            exp_data   = in_data;
            data_known = 1'b1;
        end
    end

    // Compare process: every falling edge
    always @(negedge clk) begin
        chk("ctrl", 160'(out_ctrl), 160'(exp_ctrl));
        if (data_known) chk("data", 160'(out_data), 160'(exp_data));
        chk("stall_cnt", 160'(stall_cnt), 160'(exp_stall));
        chk("flush_cnt", 160'(flush_cnt), 160'(exp_flush));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [3:0] exe, input logic mr, input logic mw,
                             input logic wb, input logic s, input logic b,
                             input logic [DW-1:0] rn, input logic [3:0] dest);
        valid_in         = 1'b1;
        exe_cmd_in       = exe;
        mem_read_in      = mr;
        mem_write_in     = mw;
        wb_en_in         = wb;
        s_in             = s;
        b_in             = b;
        val_rn_in        = rn;
        dest_in          = dest;
        pc_in            = $urandom;
        val_rm_in        = $urandom;
        imm_in           = 1'($urandom_range(1, 0));
        shift_operand_in = 12'($urandom_range(4095, 0));
        signed_imm24_in  = 24'($urandom_range(24'hFFFFFF, 0));
        src1_in          = 4'($urandom_range(15, 0));
        src2_in          = 4'($urandom_range(15, 0));
        c_in             = 1'($urandom_range(1, 0));
    endtask

    task automatic set_all_nonzero();
        set_instr(4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'hE);
        pc_in            = 32'h0000_1004;
        val_rm_in        = 32'hCAFE_F00D;
        imm_in           = 1'b1;
        shift_operand_in = 12'hABC;
        signed_imm24_in  = 24'h123456;
        src1_in          = 4'h5;
        src2_in          = 4'h6;
        c_in             = 1'b1;
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ctrl", 160'(out_ctrl), 160'd0);
        chk("rst_data", 160'(out_data), 160'd0);
        chk("rst_stall", 160'(stall_cnt), 160'd0);
        chk("rst_flush", 160'(flush_cnt), 160'd0);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n  = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
        set_all_nonzero();
        #1;
        chk("por_ctrl", 160'(out_ctrl), 160'd0);
        chk("por_data", 160'(out_data), 160'd0);
        step();
        step();
        chk("por_hold_ctrl", 160'(out_ctrl), 160'd0);
        #1 rst_n = 1'b1;

        // Fill the stage with nonzero content and a nonzero stall count,
        // then pulse reset mid-stall.
        step();
        chk("nz_load_exe", 160'(exe_cmd_out), 160'hF);
        freeze = 1'b1;
        step();
        chk("nz_stall", 160'(stall_cnt), 160'd1);
        reset_pulse();
        freeze = 1'b0;

        // First capture after reset release
        set_instr(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'd3);
        step();
        chk("first_exe", 160'(exe_cmd_out), 160'd2);
        chk("first_wb", 160'(wb_en_out), 160'd1);
        chk("first_dest", 160'(dest_out), 160'd3);

        // Pipeline flow: ADD, SUB, LDR
        set_instr(4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7, 4'd1);
        step();
        chk("add_exe", 160'(exe_cmd_out), 160'd2);
        set_instr(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h9, 4'd2);
        step();
        chk("sub_exe", 160'(exe_cmd_out), 160'd4);
        chk("sub_dest", 160'(dest_out), 160'd2);
        set_instr(4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 4'd4);
        step();
        chk("ldr_mem_read", 160'(mem_read_out), 160'd1);
        chk("ldr_val_rn", 160'(val_rn_out), 160'h10);

        // Freeze: MOV held for 3 cycles while inputs change
        set_instr(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h55, 4'd7);
        step();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(4'(i + 8), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, $urandom, 4'(i));
            step();
            chk("frz_exe", 160'(exe_cmd_out), 160'd1);
            chk("frz_dest", 160'(dest_out), 160'd7);
        end
        chk("frz_stall", 160'(stall_cnt), 160'd3);
        freeze = 1'b0;

        // Flush: STR then a bubble while a writing ADD sits at the input
        set_instr(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 4'd0);
        step();
        chk("str_mem_write", 160'(mem_write_out), 160'd1);
        set_instr(4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h30, 4'd9);
        flush = 1'b1;
        step();
        chk("fl_mem_write", 160'(mem_write_out), 160'd0);
        chk("fl_wb", 160'(wb_en_out), 160'd0);
        chk("fl_valid", 160'(valid_out), 160'd0);
        chk("fl_exe", 160'(exe_cmd_out), 160'd0);
        chk("fl_cnt", 160'(flush_cnt), 160'd1);
        flush = 1'b0;

        // Freeze and flush together: hold, only stall_cnt moves
        set_instr(4'hD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 4'd5);
        step();
        freeze = 1'b1;
        flush  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_instr(4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, $urandom, 4'd12);
            step();
            chk("ff_exe", 160'(exe_cmd_out), 160'hD);
            chk("ff_valid", 160'(valid_out), 160'd1);
        end
        chk("ff_stall", 160'(stall_cnt), 160'd5);
        chk("ff_flush", 160'(flush_cnt), 160'd1);
        freeze = 1'b0;
        flush  = 1'b0;

        // Invalid instruction and branch pass through as given
        set_instr(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0);
        valid_in = 1'b0;
        step();
        chk("inv_valid", 160'(valid_out), 160'd0);
        set_instr(4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4'd0);
        signed_imm24_in = 24'hFFFFF0;
        step();
        chk("br_b", 160'(b_out), 160'd1);
        chk("br_imm24", 160'(signed_imm24_out), 160'hFFFFF0);

        // Mixed directed/random traffic, checked by the compare process
        for (int i = 0; i < 30; i++) begin
            set_instr(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                      1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                      $urandom, 4'($urandom_range(15, 0)));
            freeze = ($urandom_range(3, 0) == 0);
            flush  = ($urandom_range(3, 0) == 0);
            step();
        end
        freeze = 1'b0;
        flush  = 1'b0;

        // Saturation: 20 frozen cycles then 20 flushed cycles from zero
        reset_pulse();
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall", 160'(stall_cnt), 160'd15);
        step();
        chk("sat_stall_hold", 160'(stall_cnt), 160'd15);
        freeze = 1'b0;
        flush  = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("sat_flush", 160'(flush_cnt), 160'd15);
        chk("sat_flush_stall", 160'(stall_cnt), 160'd15);
        flush = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net: the bench must never hang
    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- ID/EXE pipeline register of the ARM core, directly downstream of the instruction decoder's control unit.
- Captures the control unit's outputs (EXE_CMD, mem_read, mem_write, wb_en, S, B), the register-file read values, the immediate/shift fields, the destination register and the carry flag. Presents them to the execute stage one cycle later.
- Implements hazard freeze, branch flush (bubble insertion) and saturating stall/flush event counters for debug.

Parameters:
- DW, 32, datapath width (PC and register values)
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  hazard stall: hold all stage contents
- flush  in  1  branch taken: replace incoming instruction with bubble
- valid_in  in  1  ID stage holds a real instruction
- pc_in  in  DW  PC+4 of the ID instruction
- exe_cmd_in  in  4  ALU command from control unit
- mem_read_in, mem_write_in, wb_en_in, s_in, b_in  in  1 each  control bits from control unit
- val_rn_in, val_rm_in  in  DW  register-file read data
- imm_in  in  1  immediate-operand flag (instruction bit 25)
- shift_operand_in  in  12  shifter operand field
- signed_imm24_in  in  24  branch offset
- dest_in  in  4  destination register number
- src1_in, src2_in  in  4 each  source register numbers, forwarded for hazard/forwarding units
- c_in  in  1  carry flag from the status register
- valid_out, pc_out, exe_cmd_out, mem_read_out, mem_write_out, wb_en_out, s_out, b_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm24_out, dest_out, src1_out, src2_out, c_out  out  same widths  registered copies
- stall_cnt  out  CNT_W  cycles with freeze=1
- flush_cnt  out  CNT_W  cycles with flush=1 and freeze=0

Behaviour:
- Reset (rst_n=0, asynchronous): every output clears to 0, counters included, and stays 0 while rst_n is low. First capture happens on the first rising edge after rst_n rises.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Per rising edge, priority is highest first:
  - freeze=1 (HOLD): all payload and control outputs keep their values; stall_cnt increments.
  - flush=1 (BUBBLE): valid_out, wb_en_out, mem_read_out, mem_write_out, s_out and b_out become 0, and exe_cmd_out becomes 0. Data fields (pc, values, fields, dest, src, c) may capture inputs, but the bench checks only the control bits. flush_cnt increments.
  - otherwise (LOAD): all outputs capture their inputs.
- freeze and flush together: freeze wins; the stage holds; only stall_cnt increments. The hazard unit re-asserts flush on a later cycle if still needed.
- valid_in=0 with LOAD: captured as given. The control unit already drives zero control on invalid instructions, so no extra masking is applied.
- b_in=1: exe_cmd_in is don't-care. Capture it as given and never feed X into the counter logic.
- Counters saturate at 2^CNT_W-1 with no wrap. They are not affected by data values.
- State summary: there is no explicit FSM beyond the three per-cycle modes (HOLD, BUBBLE, LOAD), chosen combinationally each edge from freeze and flush.
- Reset asserted mid-stall or mid-flush: outputs and counters clear immediately, without waiting for a clock edge.

Test Plan:
- Reset: drive all inputs nonzero, pulse rst_n low between edges -> all outputs 0 immediately; after release, first edge with exe_cmd_in=4'b0010, wb_en_in=1, dest_in=3 -> exe_cmd_out=2, wb_en_out=1, dest_out=3 one cycle later.
- Pipeline flow: 3 consecutive instructions (ADD, SUB, LDR with mem_read_in=1, val_rn_in=32'h10) -> each appears exactly one cycle after issue; LDR gives mem_read_out=1, val_rn_out=32'h10.
- Freeze: load MOV (exe_cmd=1, wb_en=1), then freeze=1 for 3 cycles with changing inputs -> outputs stay MOV for 3 cycles; stall_cnt=3.
- Flush: load STR (mem_write_in=1), next cycle flush=1 -> mem_write_out=0, wb_en_out=0, valid_out=0, exe_cmd_out=0; flush_cnt=1.
- freeze and flush together for 2 cycles -> outputs held, stall_cnt +2, flush_cnt unchanged.
- Saturation with CNT_W=4: freeze held 20 cycles -> stall_cnt=15, then stays 15.
